onewire_rom_reader: RTL and testbench

Parametrised 1-Wire master that issues READ ROM (0x33) to a single-drop device (DS2411 or any 1-Wire slave) on one of N_CH buses and returns the 64-bit ROM code. It checks the Dallas CRC-8 and retries on missing presence or bad CRC. It runs entirely in the `clk` domain using a 1 µs clock-enable, with no derived clocks. It sits between board-ID/housekeeping logic and the open-drain 1-Wire pads.

---
 rtl/onewire_pkg.sv | 34 +++
 rtl/onewire_crc8.sv | 22 ++
 rtl/onewire_rom_reader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_onewire_rom_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared types, bus timing constants and CRC helper for the 1-Wire ROM reader.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_PRES,
        ST_CMD,
        ST_READ,
        ST_CHECK,
        ST_FAIL,
        ST_DONE
    } ow_state_t;

    // Bus timing in microseconds.
    localparam int unsigned T_RSTL    = 480;
    localparam int unsigned T_PDS     = 70;
    localparam int unsigned T_RST_TOT = 480;
    localparam int unsigned T_SLOT    = 70;
    localparam int unsigned T_LOW0    = 60;
    localparam int unsigned T_LOW1    = 6;
    localparam int unsigned T_RDS     = 15;

    localparam logic [7:0] CMD_READ_ROM = 8'h33;
    localparam logic [7:0] CRC8_POLY    = 8'h8C;

    // One step of the reflected Dallas CRC-8, consuming a single bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? CRC8_POLY : '0);
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8 engine: one bit per enable, synchronous clear.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    // Accumulate one received bit per enable; clear restarts from 0x00.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/onewire_rom_reader.sv
// 1-Wire master issuing READ ROM on one of N_CH buses, with CRC check and retry.
module onewire_rom_reader
    import onewire_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned N_CH        = 1,
    parameter int unsigned MAX_RETRY   = 2,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [CH_W-1:0] ch_sel,
    input  logic [N_CH-1:0] dq_in,
    output logic [N_CH-1:0] dq_oe,
    output logic            busy,
    output logic            done,
    output logic [63:0]     rom,
    output logic            rom_valid,
    output logic            presence_err,
    output logic            crc_err
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ATT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TM_W  = 10;

    localparam logic [TM_W-1:0] TM_RSTL_END = TM_W'(T_RSTL - 1);
    localparam logic [TM_W-1:0] TM_PDS_SMP  = TM_W'(T_PDS - 1);
    localparam logic [TM_W-1:0] TM_PRES_END = TM_W'(T_RST_TOT - 1);
    localparam logic [TM_W-1:0] TM_SLOT_END = TM_W'(T_SLOT - 1);
    localparam logic [TM_W-1:0] TM_RDS_SMP  = TM_W'(T_RDS - 1);
    localparam logic [TM_W-1:0] TM_LOW0     = TM_W'(T_LOW0);
    localparam logic [TM_W-1:0] TM_LOW1     = TM_W'(T_LOW1);

    ow_state_t        state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [N_CH-1:0]  dq_s1, dq_s2;
    logic [TM_W-1:0]  t;
    logic [5:0]       bit_idx;
    logic [ATT_W-1:0] attempt;
    logic [CH_W-1:0]  ch;
    logic             present;
    logic             fail_crc;
    logic [7:0]       crc;
    logic [N_CH-1:0]  ch_mask;
    logic             dq_bit;
    logic             cmd_bit;
    logic             ch_ok;

    // FSM strobes
    logic go_acc, start, t_clr, bit_clr, bit_inc, crc_clr, crc_en;
    logic smp_pres, smp_rom, set_valid, set_perr, set_cerr, att_inc;
    logic fail_pres_set, fail_crc_set, drive_low;

    assign tick    = (div_cnt == DIV_W'(DIV - 1));
    assign dq_bit  = dq_s2[ch];
    assign cmd_bit = CMD_READ_ROM[bit_idx[2:0]];
    assign ch_ok   = (32'(ch_sel) < N_CH);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // Free-running microsecond tick divider.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchronisers on every pad input; idle bus reads high.
    always_ff @(posedge clk) begin
        if (reset) begin
            dq_s1 <= '1;
            dq_s2 <= '1;
        end else begin
            dq_s1 <= dq_in;
            dq_s2 <= dq_s1;
        end
    end

    // One-hot mask of the latched bus.
    always_comb begin
        ch_mask     = '0;
        ch_mask[ch] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, datapath strobes and bus drive request.
    always_comb begin
        state_next    = state;
        go_acc        = 1'b0;
        start         = 1'b0;
        t_clr         = 1'b0;
        bit_clr       = 1'b0;
        bit_inc       = 1'b0;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        smp_pres      = 1'b0;
        smp_rom       = 1'b0;
        set_valid     = 1'b0;
        set_perr      = 1'b0;
        set_cerr      = 1'b0;
        att_inc       = 1'b0;
        fail_pres_set = 1'b0;
        fail_crc_set  = 1'b0;
        drive_low     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (go) begin
                    go_acc = 1'b1;
                    if (ch_ok) begin
                        start      = 1'b1;
                        bit_clr    = 1'b1;
                        crc_clr    = 1'b1;
                        state_next = ST_RST_LOW;
                    end else begin
                        set_perr   = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RST_LOW: begin
                drive_low = 1'b1;
                if (tick && t == TM_RSTL_END) state_next = ST_PRES;
            end
            ST_PRES: begin
                if (tick && t == TM_PDS_SMP) smp_pres = 1'b1;
                if (tick && t == TM_PRES_END) begin
                    if (present) begin
                        state_next = ST_CMD;
                    end else begin
                        fail_pres_set = 1'b1;
                        state_next    = ST_FAIL;
                    end
                end
            end
            ST_CMD: begin
                drive_low = (t < (cmd_bit ? TM_LOW1 : TM_LOW0));
                if (tick && t == TM_SLOT_END) begin
                    t_clr = 1'b1;
                    if (bit_idx == 6'd7) begin
                        bit_clr    = 1'b1;
                        state_next = ST_READ;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            ST_READ: begin
                drive_low = (t < TM_LOW1);
                if (tick && t == TM_RDS_SMP) begin
                    smp_rom = 1'b1;
                    crc_en  = 1'b1;
                end
                if (tick && t == TM_SLOT_END) begin
                    t_clr = 1'b1;
                    if (bit_idx == 6'd63) begin
                        state_next = ST_CHECK;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (crc == 8'h00) begin
                    set_valid  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    fail_crc_set = 1'b1;
                    state_next   = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (32'(attempt) < MAX_RETRY) begin
                    att_inc    = 1'b1;
                    crc_clr    = 1'b1;
                    bit_clr    = 1'b1;
                    state_next = ST_RST_LOW;
                end else begin
                    if (fail_crc) set_cerr = 1'b1;
                    else          set_perr = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (state_next != state) t_clr = 1'b1;
    end

    // Phase timer, bit index, attempt counter, capture registers and result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            t            <= '0;
            bit_idx      <= '0;
            attempt      <= '0;
            ch           <= '0;
            present      <= 1'b0;
            fail_crc     <= 1'b0;
            rom          <= '0;
            rom_valid    <= 1'b0;
            presence_err <= 1'b0;
            crc_err      <= 1'b0;
        end else begin
            if (t_clr)     t <= '0;
            else if (tick) t <= t + TM_W'(1);

            if (bit_clr)      bit_idx <= '0;
            else if (bit_inc) bit_idx <= bit_idx + 6'd1;

            if (go_acc) begin
                rom          <= '0;
                rom_valid    <= 1'b0;
                presence_err <= 1'b0;
                crc_err      <= 1'b0;
            end
            if (start) begin
                ch       <= ch_sel;
                attempt  <= '0;
                present  <= 1'b0;
                fail_crc <= 1'b0;
            end
            if (att_inc) begin
                attempt <= attempt + ATT_W'(1);
                present <= 1'b0;
            end

            if (smp_pres)      present  <= ~dq_bit;
            if (fail_pres_set) fail_crc <= 1'b0;
            if (fail_crc_set)  fail_crc <= 1'b1;

            if (smp_rom) rom[bit_idx] <= dq_bit;

            if (set_valid) rom_valid    <= 1'b1;
            if (set_perr)  presence_err <= 1'b1;
            if (set_cerr)  crc_err      <= 1'b1;
        end
    end

    // Registered open-drain enables; only the latched bus is ever pulled.
    always_ff @(posedge clk) begin
        if (reset) begin
            dq_oe <= '0;
        end else begin
            dq_oe <= drive_low ? ch_mask : '0;
        end
    end

    onewire_crc8 u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clr),
        .en    (crc_en),
        .din   (dq_bit),
        .crc   (crc)
    );

endmodule

// File: tb/tb_onewire_rom_reader.sv
// Scoreboard bench for onewire_rom_reader with a behavioural 1-Wire slave.
module tb_onewire_rom_reader;

    localparam int unsigned N_CH   = 3;
    localparam logic [63:0] ROM_ID = 64'hA200000001B81C02;

    typedef struct {
        logic [63:0] rom;
        logic        valid;
        logic        perr;
        logic        cerr;
        int          resets;
        int          base;
        logic        chk_cmd;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            go = 1'b0;
    logic [1:0]      ch_sel = '0;
    logic [N_CH-1:0] dq_in;
    logic [N_CH-1:0] dq_oe;
    logic            busy, done;
    logic [63:0]     rom;
    logic            rom_valid, presence_err, crc_err;

    onewire_rom_reader #(
        .CLK_FREQ_HZ (1_000_000),
        .N_CH        (N_CH),
        .MAX_RETRY   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .ch_sel       (ch_sel),
        .dq_in        (dq_in),
        .dq_oe        (dq_oe),
        .busy         (busy),
        .done         (done),
        .rom          (rom),
        .rom_valid    (rom_valid),
        .presence_err (presence_err),
        .crc_err      (crc_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model (one clk = one microsecond) ----------------
    int          dev_ch = 0;
    logic        dev_en = 1'b0;
    int          flip_mode = 0;
    logic        dev_pull = 1'b0;
    logic [63:0] rom_img = ROM_ID;
    int          low_len = 0;
    logic        prev_oe = 1'b0;
    logic        oe_m;
    int          phase = 0;
    int          cmd_cnt = 0;
    logic [7:0]  cmd_sr = '0;
    logic [7:0]  last_cmd = '0;
    int          rd_idx = 0;
    int          pull_cnt = 0;
    int          pres_wait = 0;
    int          n_resets = 0;
    int          txn_base = 0;
    logic        mbit;

    always_comb begin
        dq_in = ~dq_oe;
        if (dev_pull) dq_in[dev_ch] = 1'b0;
    end

    always @(negedge clk) begin
        oe_m = dq_oe[dev_ch];
        if (pres_wait > 0) begin
            pres_wait--;
            if (pres_wait == 0) pull_cnt = 100;
        end
        if (pull_cnt > 0) pull_cnt--;
        if (oe_m) begin
            low_len++;
        end else if (prev_oe) begin
            if (low_len >= 400) begin
                check("rst_len", 64'(low_len), 64'd480);
                n_resets++;
                phase   = 1;
                cmd_cnt = 0;
                if (dev_en) pres_wait = 15;
            end else if (phase == 1) begin
                cmd_sr[cmd_cnt] = (low_len < 15);
                cmd_cnt++;
                if (cmd_cnt == 8) begin
                    last_cmd = cmd_sr;
                    phase    = 2;
                    rd_idx   = 0;
                end
            end else if (phase == 2) begin
                mbit = rom_img[rd_idx];
                if (rd_idx == 10 && (flip_mode == 2 || (flip_mode == 1 && n_resets - txn_base == 1)))
                    mbit = ~mbit;
                if (!mbit && dev_en) pull_cnt = 25;
                rd_idx++;
                if (rd_idx == 64) phase = 0;
            end
            low_len = 0;
        end
        prev_oe  = oe_m;
        dev_pull = dev_en && (pull_cnt > 0);
    end

    // ---------------- scoreboard / monitor ----------------
    exp_t            exp_q[$];
    exp_t            e;
    int              done_cnt = 0;
    int              exp_done = 0;
    int              stray = 0;
    logic [N_CH-1:0] allowed = '0;

    always @(negedge clk) begin
        if ((dq_oe & ~allowed) != '0) stray++;
        if (done) begin
            done_cnt++;
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rom", rom, e.rom);
                check("rom_valid", 64'(rom_valid), 64'(e.valid));
                check("presence_err", 64'(presence_err), 64'(e.perr));
                check("crc_err", 64'(crc_err), 64'(e.cerr));
                check("attempts", 64'(n_resets - e.base), 64'(e.resets));
                if (e.chk_cmd) check("cmd_byte", 64'(last_cmd), 64'h33);
            end
        end
    end

    // Pulse go on the given bus; optionally queue the expected outcome.
    task automatic launch(input logic [1:0] ch, input logic [N_CH-1:0] allow,
                          input logic push, input logic [63:0] erom, input logic ev,
                          input logic ep, input logic ec, input int eres, input logic ecmd);
        exp_t x;
        allowed  = allow;
        txn_base = n_resets;
        if (push) begin
            x.rom = erom; x.valid = ev; x.perr = ep; x.cerr = ec;
            x.resets = eres; x.base = n_resets; x.chk_cmd = ecmd;
            exp_q.push_back(x);
        end
        exp_done++;
        @(negedge clk);
        ch_sel = ch;
        go     = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
    endtask

    // Wait for done with a cycle budget; optionally pulse go on the done cycle.
    task automatic wait_done(input int budget, input logic go_on_done, output int lat);
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            check("done_timeout", 64'(lat), 64'(budget + 1));
        end else if (go_on_done) begin
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
    endtask

    int lat;
    int waited;

    initial begin
        repeat (5) @(negedge clk);
        check("rst_dq_oe", 64'(dq_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rom", rom, 64'd0);
        check("rst_valid", 64'(rom_valid), 64'd0);
        check("rst_perr", 64'(presence_err), 64'd0);
        check("rst_cerr", 64'(crc_err), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // good read on bus 2, go pulsed while busy and on the done cycle
        dev_en = 1'b1; dev_ch = 2; flip_mode = 0;
        launch(2'd2, 3'b100, 1'b1, ROM_ID, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        repeat (1000) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(20000, 1'b1, lat);
        repeat (20) @(negedge clk);
        check("single_done", 64'(done_cnt), 64'(exp_done));
        check("idle_after", 64'(busy), 64'd0);
        check("rom_hold", rom, ROM_ID);

        // no device on bus 0
        dev_en = 1'b0; dev_ch = 0;
        launch(2'd0, 3'b001, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        wait_done(20000, 1'b0, lat);
        repeat (5) @(negedge clk);

        // corrupted bit 10 on the first attempt only
        dev_en = 1'b1; dev_ch = 0; flip_mode = 1;
        launch(2'd0, 3'b001, 1'b1, ROM_ID, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        wait_done(20000, 1'b0, lat);
        repeat (5) @(negedge clk);

        // corrupted bit 10 on every attempt
        flip_mode = 2;
        launch(2'd0, 3'b001, 1'b1, ROM_ID ^ (64'd1 << 10), 1'b0, 1'b0, 1'b1, 3, 1'b1);
        wait_done(20000, 1'b0, lat);
        repeat (5) @(negedge clk);

        // out-of-range bus select
        flip_mode = 0;
        launch(2'd3, 3'b000, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        wait_done(10, 1'b0, lat);
        check("badch_latency", 64'(lat <= 1), 64'd1);
        repeat (5) @(negedge clk);

        // reset during read slot 30, no done expected
        launch(2'd0, 3'b001, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exp_done--;
        waited = 0;
        while ((phase != 2 || rd_idx < 30) && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        while (!dq_oe[0] && waited < 10200) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reached", 64'(dq_oe[0]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_dq_oe", 64'(dq_oe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(exp_done));

        // read after abort
        launch(2'd0, 3'b001, 1'b1, ROM_ID, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        wait_done(20000, 1'b0, lat);
        repeat (10) @(negedge clk);

        check("stray_oe", 64'(stray), 64'd0);
        check("done_total", 64'(done_cnt), 64'(exp_done));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
